priority_code_decoder: RTL and testbench

- Reverse path of the 4-to-2 priority encoder: accepts encoded request codes (y[1:0] plus valid flag v) through a valid/ready handshake and buffers them in a small FIFO.
- Regenerates each code as a registered one-hot request line, held for HOLD_CYCLES cycles and followed by GAP_CYCLES idle cycles.
- Sits downstream of the encoder to drive the re-expanded request lines at the far end of the link.

---
 rtl/priority_code_decoder_if.sv | 22 ++
 rtl/priority_code_decoder.sv | 127 ++++++++++++
 tb/tb_priority_code_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/priority_code_decoder_if.sv
// Handshake and decoded-output bundle for the priority code decoder.
// The producer pushes encoded codes; the decoder returns one-hot request lines.
interface priority_code_decoder_if;
    logic [1:0] in_y;
    logic       in_v;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_x;
    logic       out_valid;
    logic       out_null;
    logic       busy;

    modport master (
        output in_y, in_v, in_valid,
        input  in_ready, out_x, out_valid, out_null, busy
    );

    modport slave (
        input  in_y, in_v, in_valid,
        output in_ready, out_x, out_valid, out_null, busy
    );
endinterface

// File: rtl/priority_code_decoder.sv
// Re-expands buffered {v,y} priority codes into one-hot request lines,
// each held for HOLD_CYCLES cycles and followed by GAP_CYCLES idle cycles.
module priority_code_decoder #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    priority_code_decoder_if.slave  bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam bit GAP_EN = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [2:0]    head;

    function automatic logic [3:0] decode(input logic [2:0] entry);
        return entry[2] ? 4'(4'b0001 << entry[1:0]) : 4'b0000;
    endfunction

    // MSB of the pointers separates the wrapped-full case from empty
    assign empty        = (wptr == rptr);
    assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push         = bus.in_valid && !full;
    assign head         = mem[rptr[AW-1:0]];
    assign bus.in_ready = !full;
    assign bus.busy     = (state != IDLE) || !empty;

    // Pop whenever the FSM is ready for the next code and one is buffered
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            case (state)
                IDLE:    pop = 1'b1;
                HOLD:    pop = (cnt == '0) && !GAP_EN;
                GAP:     pop = (cnt == '0);
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {bus.in_v, bus.in_y};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    // Hold/gap sequencer; a pop reloads HOLD directly from any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_x     <= 4'b0000;
            bus.out_valid <= 1'b0;
            bus.out_null  <= 1'b0;
        end else begin
            bus.out_null <= 1'b0;
            if (pop) begin
                bus.out_x     <= decode(head);
                bus.out_valid <= 1'b1;
                bus.out_null  <= !head[2];
                cnt           <= HOLD_LOAD;
                state         <= HOLD;
            end else begin
                case (state)
                    IDLE: begin
                        bus.out_x     <= 4'b0000;
                        bus.out_valid <= 1'b0;
                    end
                    HOLD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            bus.out_x     <= 4'b0000;
                            bus.out_valid <= 1'b0;
                            cnt           <= GAP_LOAD;
                            state         <= GAP_EN ? GAP : IDLE;
                        end
                    end
                    GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        bus.out_x     <= 4'b0000;
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_priority_code_decoder.sv
// Directed bench for priority_code_decoder: default-parameter instance plus a
// HOLD_CYCLES=1 / GAP_CYCLES=0 instance for back-to-back reload.
module tb_priority_code_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    priority_code_decoder_if bus0 ();
    priority_code_decoder_if bus1 ();

    priority_code_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .FIFO_DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    priority_code_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic       v;
        logic [1:0] y;
        logic [3:0] exp_x;
        logic       exp_null;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Output monitor on dut0: one record per out_valid burst
    logic [3:0] mon_code [64];
    int         mon_len  [64];
    int         mon_start[64];
    int         mon_n = 0;
    int         cyc   = 0;
    logic       prev_v = 1'b0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        prev_v <= bus0.out_valid;
        if (bus0.out_valid && mon_n < 64) begin
            if (!prev_v) begin
                mon_code[mon_n]  <= bus0.out_x;
                mon_len[mon_n]   <= 1;
                mon_start[mon_n] <= cyc;
                mon_n            <= mon_n + 1;
            end else if (mon_n > 0) begin
                mon_len[mon_n-1] <= mon_len[mon_n-1] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   exp_wait[4];
        int   base;
        int   waits;
        logic stale;
        logic exp_null;

        vecs[0] = '{v: 1'b1, y: 2'd0, exp_x: 4'b0001, exp_null: 1'b0};
        vecs[1] = '{v: 1'b1, y: 2'd1, exp_x: 4'b0010, exp_null: 1'b0};
        vecs[2] = '{v: 1'b1, y: 2'd2, exp_x: 4'b0100, exp_null: 1'b0};
        vecs[3] = '{v: 1'b1, y: 2'd3, exp_x: 4'b1000, exp_null: 1'b0};
        vecs[4] = '{v: 1'b0, y: 2'd3, exp_x: 4'b0000, exp_null: 1'b1};
        vecs[5] = '{v: 1'b0, y: 2'd0, exp_x: 4'b0000, exp_null: 1'b1};
        exp_wait = '{0, 0, 0, 4};

        rst           = 1'b1;
        bus0.in_valid = 1'b0;
        bus0.in_v     = 1'b0;
        bus0.in_y     = 2'd0;
        bus1.in_valid = 1'b0;
        bus1.in_v     = 1'b0;
        bus1.in_y     = 2'd0;
        step();
        step();
        check("rst_out_x",     32'(bus0.out_x),     32'h0);
        check("rst_out_valid", 32'(bus0.out_valid), 32'h0);
        check("rst_out_null",  32'(bus0.out_null),  32'h0);
        check("rst_busy",      32'(bus0.busy),      32'h0);
        check("rst_in_ready",  32'(bus0.in_ready),  32'h1);
        rst = 1'b0;
        step();

        // Single codes: push at edge k, held k+1..k+4, zero at k+5, idle at k+6
        for (int i = 0; i < 6; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_v     = vecs[i].v;
            bus0.in_y     = vecs[i].y;
            step();
            bus0.in_valid = 1'b0;
            check($sformatf("v%0d_k_valid", i), 32'(bus0.out_valid), 32'h0);
            check($sformatf("v%0d_k_busy", i),  32'(bus0.busy),      32'h1);
            for (int h = 1; h <= 4; h++) begin
                step();
                exp_null = (h == 1) ? vecs[i].exp_null : 1'b0;
                check($sformatf("v%0d_h%0d_x", i, h),     32'(bus0.out_x),     32'(vecs[i].exp_x));
                check($sformatf("v%0d_h%0d_valid", i, h), 32'(bus0.out_valid), 32'h1);
                check($sformatf("v%0d_h%0d_null", i, h),  32'(bus0.out_null),  32'(exp_null));
            end
            step();
            check($sformatf("v%0d_gap_x", i),     32'(bus0.out_x),     32'h0);
            check($sformatf("v%0d_gap_valid", i), 32'(bus0.out_valid), 32'h0);
            check($sformatf("v%0d_gap_busy", i),  32'(bus0.busy),      32'h1);
            step();
            check($sformatf("v%0d_idle_busy", i), 32'(bus0.busy),      32'h0);
            check($sformatf("v%0d_idle_valid", i), 32'(bus0.out_valid), 32'h0);
        end

        // Reset mid-hold with a second code still buffered
        bus0.in_valid = 1'b1;
        bus0.in_v     = 1'b1;
        bus0.in_y     = 2'd1;
        step();
        bus0.in_y     = 2'd2;
        step();
        bus0.in_valid = 1'b0;
        step();
        step();
        check("mid_hold_valid", 32'(bus0.out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_x",     32'(bus0.out_x),     32'h0);
        check("async_rst_valid", 32'(bus0.out_valid), 32'h0);
        check("async_rst_busy",  32'(bus0.busy),      32'h0);
        step();
        step();
        rst = 1'b0;
        check("post_rst_ready", 32'(bus0.in_ready), 32'h1);
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus0.out_valid || bus0.busy) stale = 1'b1;
        end
        check("post_rst_no_stale", 32'(stale), 32'h0);

        // Backpressure: codes y=0..3 with in_valid held, FIFO fills after two
        base = mon_n;
        for (int c = 0; c < 4; c++) begin
            bus0.in_valid = 1'b1;
            bus0.in_v     = 1'b1;
            bus0.in_y     = 2'(c);
            waits = 0;
            while (!bus0.in_ready && waits < 50) begin
                step();
                waits++;
            end
            check($sformatf("bp_wait%0d", c), 32'(waits), 32'(exp_wait[c]));
            step();
        end
        bus0.in_valid = 1'b0;
        waits = 0;
        while (bus0.busy && waits < 100) begin
            step();
            waits++;
        end
        check("bp_drain_done", 32'(bus0.busy), 32'h0);
        step();
        check("bp_code_count", 32'(mon_n - base), 32'd4);
        for (int c = 0; c < 4; c++) begin
            if (base + c < 64) begin
                check($sformatf("bp_code%0d", c), 32'(mon_code[base+c]), 32'(4'b0001 << c));
                check($sformatf("bp_len%0d", c),  32'(mon_len[base+c]),  32'd4);
                if (c > 0) begin
                    check($sformatf("bp_space%0d", c),
                          32'(mon_start[base+c] - mon_start[base+c-1]), 32'd5);
                end
            end
        end

        // HOLD=1, GAP=0: y=3 then y=0 reload with no zero cycle between
        bus1.in_valid = 1'b1;
        bus1.in_v     = 1'b1;
        bus1.in_y     = 2'd3;
        step();
        check("g0_k_valid", 32'(bus1.out_valid), 32'h0);
        check("g0_k_ready", 32'(bus1.in_ready),  32'h1);
        bus1.in_y = 2'd0;
        step();
        bus1.in_valid = 1'b0;
        check("g0_c1_x",     32'(bus1.out_x),     32'h8);
        check("g0_c1_valid", 32'(bus1.out_valid), 32'h1);
        step();
        check("g0_c2_x",     32'(bus1.out_x),     32'h1);
        check("g0_c2_valid", 32'(bus1.out_valid), 32'h1);
        step();
        check("g0_c3_x",     32'(bus1.out_x),     32'h0);
        check("g0_c3_valid", 32'(bus1.out_valid), 32'h0);
        check("g0_c3_busy",  32'(bus1.busy),      32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
